posit_mult_4: RTL and testbench

POSIT_MULT_4 -- requirements
Module: posit_mult_4

---
 rtl/posit_mult_4.sv | 157 +++++++++++++++
 tb/tb_posit_mult_4.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_4.sv
// posit_mult_4: fully pipelined posit multiplier, result four cycles after start.
// Define POSIT_MULT_RNE_ROUND_EN for round-to-nearest-even; default build truncates toward zero.
module posit_mult_4 #(
    parameter int N  = 32,
    parameter int es = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         start,
    output logic [N-1:0] result,
    output logic         inf,
    output logic         zero,
    output logic         done
);
    localparam int FW  = N - 1 - es;          // fraction bits of a decoded operand
    localparam int MW  = FW + 1;              // mantissa with hidden one
    localparam int PW  = 2 * MW;              // raw product
    localparam int FPW = PW - 1;              // normalised product fraction
    localparam int KW  = $clog2(N) + 1;       // signed regime value
    localparam int SW  = KW + es + 2;         // signed combined scale
    localparam int EW  = 2 + es + FPW + N - 2; // encode buffer, wide enough to never lose bits

    localparam logic [N-1:0] NaR    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MinPos = {{(N-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] KMax = SW'(N - 2);
    localparam logic signed [SW-1:0] KMin = SW'(2 - N);

`ifdef POSIT_MULT_RNE_ROUND_EN
    localparam bit RneEn = 1'b1;
`else
    localparam bit RneEn = 1'b0;
`endif

    typedef struct packed {
        logic          nar;
        logic          zer;
        logic          sgn;
        logic [KW-1:0] k;
        logic [es-1:0] e;
        logic [FW-1:0] f;
    } dec_t;

    function automatic dec_t decode(input logic [N-1:0] x);
        dec_t         d;
        logic [N-2:0] body;
        logic [N-2:0] rest;
        int           m;
        logic         run;
        body = x[N-1] ? -x[N-2:0] : x[N-2:0];
        m    = 0;
        run  = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && body[i] == body[N-2]) m++;
            else run = 1'b0;
        end
        // Drop the regime run and its terminator; bits cut off by a long regime read as zero.
        rest  = body << (m + 1);
        d.nar = x == NaR;
        d.zer = x == '0;
        d.sgn = x[N-1];
        d.k   = body[N-2] ? KW'(m - 1) : KW'(-m);
        d.e   = rest[N-2 -: es];
        d.f   = rest[N-2-es:0];
        return d;
    endfunction

    logic [3:0]              v_q;
    logic [N-1:0]            in1_q, in2_q;
    dec_t                    dec_a_q, dec_b_q;
    logic                    sgn2_q, nar2_q, zer2_q;
    logic signed [SW-1:0]    ka, kb, scale2_d, scale2_q;
    logic [PW-1:0]           prod2_d, prod2_q;
    logic                    sgn3_q, nar3_q, zer3_q;
    logic signed [SW-1:0]    scale3_d, scale3_q;
    logic [FPW-1:0]          frac3_d, frac3_q;
    logic signed [SW-1:0]    k4;
    logic [SW-1:0]           sh4;
    logic [es-1:0]           e4;
    logic [EW-1:0]           ext4, ext_sh4;
    logic [N-2:0]            top4;
    logic                    guard4, sticky4, rnd4;
    logic [N-1:0]            mag4, res_d;

    always_comb begin
        ka       = SW'($signed(dec_a_q.k));
        kb       = SW'($signed(dec_b_q.k));
        scale2_d = ((ka + kb) <<< es) + SW'(dec_a_q.e) + SW'(dec_b_q.e);
        prod2_d  = PW'({1'b1, dec_a_q.f}) * PW'({1'b1, dec_b_q.f});
    end

    always_comb begin
        if (prod2_q[PW-1]) begin
            scale3_d = scale2_q + SW'(1);
            frac3_d  = prod2_q[PW-2:0];
        end else begin
            scale3_d = scale2_q;
            frac3_d  = {prod2_q[PW-3:0], 1'b0};
        end
    end

    always_comb begin
        k4      = scale3_q >>> es;
        e4      = scale3_q[es-1:0];
        // Regime of k>=0 is k+1 ones then 0, of k<0 is -k zeros then 1: seed two bits and sign-fill.
        sh4     = k4[SW-1] ? ~k4 : k4;
        ext4    = {(k4[SW-1] ? 2'b01 : 2'b10), e4, frac3_q, {(N-2){1'b0}}};
        ext_sh4 = $signed(ext4) >>> sh4;
        top4    = ext_sh4[EW-1 -: N-1];
        guard4  = ext_sh4[EW-N];
        sticky4 = |ext_sh4[EW-N-1:0];
        rnd4    = RneEn & guard4 & (sticky4 | top4[0]);
        mag4    = {1'b0, top4} + N'(rnd4);
        if (k4 >= KMax || mag4[N-1]) mag4 = MaxPos;
        else if (k4 < KMin) mag4 = MinPos;
        if (nar3_q) res_d = NaR;
        else if (zer3_q) res_d = '0;
        else res_d = sgn3_q ? -mag4 : mag4;
    end

    always_ff @(posedge aclk) begin
        in1_q    <= in1;
        in2_q    <= in2;
        dec_a_q  <= decode(in1_q);
        dec_b_q  <= decode(in2_q);
        sgn2_q   <= dec_a_q.sgn ^ dec_b_q.sgn;
        nar2_q   <= dec_a_q.nar | dec_b_q.nar;
        zer2_q   <= dec_a_q.zer | dec_b_q.zer;
        scale2_q <= scale2_d;
        prod2_q  <= prod2_d;
        sgn3_q   <= sgn2_q;
        nar3_q   <= nar2_q;
        zer3_q   <= zer2_q;
        scale3_q <= scale3_d;
        frac3_q  <= frac3_d;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            v_q    <= '0;
            done   <= 1'b0;
            result <= '0;
            inf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            v_q  <= {v_q[2:0], start};
            done <= v_q[3];
            if (v_q[3]) begin
                result <= res_d;
                inf    <= nar3_q;
                zero   <= zer3_q & ~nar3_q;
            end
        end
    end
endmodule

// File: tb/tb_posit_mult_4.sv
// tb_posit_mult_4: random and directed checks of posit_mult_4 (N=32, es=2) against a value-level model.
module tb_posit_mult_4;
    localparam int N  = 32;
    localparam int ES = 2;
    localparam int FW = N - 1 - ES;
    localparam logic [31:0] NAR    = 32'h8000_0000;
    localparam logic [31:0] MAXPOS = 32'h7FFF_FFFF;

    typedef struct {
        logic        valid;
        logic [31:0] res;
        logic        inf;
        logic        zero;
    } item_t;

    logic        aclk = 1'b0;
    logic        aresetn, start;
    logic [31:0] in1, in2, result;
    logic        inf, zero, done;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_done  = 0;
    item_t pipe[4];
    logic [31:0] exp_res;
    logic        exp_inf, exp_zero, exp_done;

    posit_mult_4 #(.N(N), .es(ES)) dut (
        .aclk(aclk), .aresetn(aresetn), .in1(in1), .in2(in2), .start(start),
        .result(result), .inf(inf), .zero(zero), .done(done)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value of a positive n-bit posit pattern as scale and a mantissa with its leading one at bit 63.
    function automatic void pval(input longint unsigned p, input int n,
                                 output int sc, output longint unsigned mt);
        int i, m, k, e;
        bit r;
        r = p[n-2];
        i = n - 2;
        m = 0;
        while (i >= 0 && p[i] == r) begin
            m++;
            i--;
        end
        i--;
        k = r ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2;
            if (i >= 0) e = e + int'(p[i]);
            i--;
        end
        mt = 64'h8000_0000_0000_0000;
        for (int b = i; b >= 0; b--) mt[62 - (i - b)] = p[b];
        sc = k * (1 << ES) + e;
    endfunction

    function automatic int cmpv(input int s1, input longint unsigned m1,
                                input int s2, input longint unsigned m2);
        if (s1 != s2) return (s1 < s2) ? -1 : 1;
        if (m1 != m2) return (m1 < m2) ? -1 : 1;
        return 0;
    endfunction

    function automatic item_t ref_mul(input logic [31:0] a, input logic [31:0] b);
        item_t it;
        int sca, scb, scp, sv, lo, hi, md;
        longint unsigned mta, mtb, mtp, prod, mv;
        logic [31:0] mag;
        it.valid = 1'b1;
        it.inf   = 1'b0;
        it.zero  = 1'b0;
        if (a == NAR || b == NAR) begin
            it.res = NAR;
            it.inf = 1'b1;
            return it;
        end
        if (a == 0 || b == 0) begin
            it.res  = 32'h0;
            it.zero = 1'b1;
            return it;
        end
        pval(longint'(a[31] ? -a : a), N, sca, mta);
        pval(longint'(b[31] ? -b : b), N, scb, mtb);
        prod = (mta >> (63 - FW)) * (mtb >> (63 - FW));
        scp  = sca + scb;
        if (prod[2*FW+1]) begin
            scp++;
            mtp = prod << (62 - 2 * FW);
        end else begin
            mtp = prod << (63 - 2 * FW);
        end
        // Largest positive posit not above the exact magnitude; below minpos clamps up.
        pval(1, N, sv, mv);
        if (cmpv(sv, mv, scp, mtp) > 0) begin
            mag = 32'h1;
        end else begin
            lo = 1;
            hi = int'(MAXPOS);
            while (lo < hi) begin
                md = lo + (hi - lo + 1) / 2;
                pval(longint'(md), N, sv, mv);
                if (cmpv(sv, mv, scp, mtp) <= 0) lo = md;
                else hi = md - 1;
            end
            mag = 32'(lo);
`ifdef POSIT_MULT_RNE_ROUND_EN
            if (mag != MAXPOS) begin
                pval(2 * longint'(mag) + 1, N + 1, sv, mv);
                md = cmpv(scp, mtp, sv, mv);
                if (md > 0 || (md == 0 && mag[0])) mag = mag + 1;
            end
`endif
        end
        it.res = (a[31] ^ b[31]) ? -mag : mag;
        return it;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = NAR;
            2: v = 32'($urandom_range(1, 255));
            3: v = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
            4: v = 32'h4000_0000 ^ ($urandom & 32'h00FF_FFFF);
            default: v = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    task automatic tick();
        item_t nw;
        if (aresetn && start) begin
            nw = ref_mul(in1, in2);
        end else begin
            nw.valid = 1'b0;
            nw.res   = 32'h0;
            nw.inf   = 1'b0;
            nw.zero  = 1'b0;
        end
        @(posedge aclk);
        if (!aresetn) begin
            for (int i = 0; i < 4; i++) pipe[i].valid = 1'b0;
            exp_res  = 32'h0;
            exp_inf  = 1'b0;
            exp_zero = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_done = pipe[3].valid;
            if (pipe[3].valid) begin
                exp_res  = pipe[3].res;
                exp_inf  = pipe[3].inf;
                exp_zero = pipe[3].zero;
            end
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nw;
        end
        #1;
        check("done", 32'(done), 32'(exp_done));
        check("result", result, exp_res);
        check("inf", 32'(inf), 32'(exp_inf));
        check("zero", 32'(zero), 32'(exp_zero));
        if (done) n_done++;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ei, input logic ez);
        in1   = a;
        in2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check({tag, ".done"}, 32'(done), 32'h1);
        check({tag, ".result"}, result, er);
        check({tag, ".inf"}, 32'(inf), 32'(ei));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pipe[i].valid = 1'b0;
        aresetn = 1'b0;
        start   = 1'b0;
        in1     = 32'h0;
        in2     = 32'h0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        directed("maxpos_x_one", 32'h7FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
        directed("sat", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        directed("neg_two", 32'hC000_0000, 32'h4800_0000, 32'hB800_0000, 1'b0, 1'b0);
        directed("zero", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
        directed("nar", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        directed("minpos_sq", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        directed("neg_minpos", 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Eight back-to-back pairs, start held high.
        n_done = 0;
        start  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in1 = rnd_op();
            in2 = rnd_op();
            tick();
        end
        start = 1'b0;
        repeat (4) tick();
        check("stream_dones", 32'(n_done), 32'd8);

        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 3) != 0);
            in1   = rnd_op();
            in2   = rnd_op();
            tick();
        end
        start = 1'b0;
        repeat (5) tick();

        // Three operations in flight, then a one-cycle reset with start asserted.
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in1 = rnd_op();
            in2 = 32'h4000_0000;
            tick();
        end
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        start   = 1'b0;
        n_done  = 0;
        repeat (6) tick();
        check("rst_no_done", 32'(n_done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {30'h0, inf, zero}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
